// File: rtl/mul_seq_if.sv
// mul_seq_if: request/response bundle for the sequential multiplier.
//   req_valid/req_ready : request handshake carrying op, a, b
//   flush               : abort whatever is in flight
//   resp_valid/resp_ready : response handshake carrying result
//   busy                : block is not idle
// master = requester/consumer side, slave = mul_seq.
interface mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output req_valid, op, a, b, flush, resp_ready,
        input  req_ready, resp_valid, result, busy
    );

    modport slave (
        input  req_valid, op, a, b, flush, resp_ready,
        output req_ready, resp_valid, result, busy
    );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: radix-2 shift-add multiplier, one multiplier bit per cycle.
//   op 00 MUL    : low half of a*b
//   op 01 MULH   : high half, signed x signed
//   op 10 MULHSU : high half, signed a x unsigned b
//   op 11 MULHU  : high half, unsigned x unsigned
// Ports: clk, rst_n (async, active low), bus (mul_seq_if.slave).
// Signed operands are reduced to magnitudes at accept; the sign is restored
// by a one-cycle two's complement (FIX) of the full product when needed.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_seq_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0]   ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] hi, lo, mcand;
    logic             neg;
    logic [CW-1:0]    cnt;
    logic             last;   // set on the final shift-add step

    logic             accept;
    logic             a_sgn, b_sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum;

    assign accept = bus.req_valid && (state == IDLE) && !bus.flush;

    // Only operands treated as signed contribute a sign; -2^(W-1) negates to
    // itself, which read as unsigned is exactly its magnitude.
    assign a_sgn = (bus.op == 2'b01 || bus.op == 2'b10) && bus.a[WIDTH-1];
    assign b_sgn = (bus.op == 2'b01) && bus.b[WIDTH-1];
    assign a_mag = a_sgn ? (~bus.a + ONE) : bus.a;
    assign b_mag = b_sgn ? (~bus.b + ONE) : bus.b;

    // Single adder; carry-out becomes the bit shifted into hi's MSB.
    assign sum = lo[0] ? ({1'b0, hi} + {1'b0, mcand}) : {1'b0, hi};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_nxt = CALC;
                // Exit decided from the registered last-step flag, one cycle
                // after the final step, keeping the counter compare off the
                // state transition path.
                CALC: if (last) state_nxt = neg ? FIX : DONE;
                FIX:  state_nxt = DONE;
                DONE: if (bus.resp_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.busy       = (state != IDLE);
        bus.resp_valid = (state == DONE);
        bus.result     = '0;
        if (state == DONE) bus.result = (op_q == 2'b00) ? lo : hi;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            last  <= 1'b0;
        end else if (bus.flush) begin
            cnt  <= '0;
            last <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q  <= bus.op;
                    mcand <= a_mag;
                    lo    <= b_mag;   // multiplier lives in lo, consumed LSB first
                    hi    <= '0;
                    neg   <= a_sgn ^ b_sgn;
                    cnt   <= '0;
                    last  <= 1'b0;
                end
                CALC: if (!last) begin
                    {hi, lo} <= {sum, lo[WIDTH-1:1]};
                    last     <= (cnt == CW'(WIDTH-1));
                    cnt      <= (cnt == CW'(WIDTH-1)) ? '0 : cnt + CW'(1);
                end
                FIX:  {hi, lo} <= ~{hi, lo} + ONE2;
                default: ;
            endcase
        end
    end
endmodule
